// File: rtl/barrido_inciso2.sv
// Truth-table sweeper: steps a 5-bit index across X..M, waits ESPERA cycles per
// index for the downstream logic to settle, then captures F_in into tabla and counts ones.
module barrido_inciso2 #(
    parameter int unsigned ESPERA = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        F_in,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        K,
    output logic        M,
    output logic        busy,
    output logic        done,
    output logic [31:0] tabla,
    output logic [5:0]  unos
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Loading ESPERA-1 and leaving DRIVE when the counter reads zero gives ESPERA DRIVE cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(ESPERA - 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] idx;
    logic [3:0] settle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 5'd0;
            settle <= 4'd0;
            tabla  <= 32'd0;
            unos   <= 6'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        tabla  <= 32'd0;
                        unos   <= 6'd0;
                        idx    <= 5'd0;
                        settle <= SETTLE_LOAD;
                    end
                end
                DRIVE: begin
                    if (settle != 4'd0) settle <= settle - 4'd1;
                end
                SAMPLE: begin
                    tabla[idx] <= F_in;
                    if (F_in) unos <= unos + 6'd1;
                    // idx stops at 31 so the last sample never wraps back to entry 0.
                    if (idx != 5'd31) begin
                        idx    <= idx + 5'd1;
                        settle <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        {X, Y, Z, K, M} = 5'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRIVE;
            end
            DRIVE: begin
                busy            = 1'b1;
                {X, Y, Z, K, M} = idx;
                if (settle == 4'd0) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                busy            = 1'b1;
                {X, Y, Z, K, M} = idx;
                state_nxt       = (idx == 5'd31) ? DONE : DRIVE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
